// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx
//
// Captures the 48-bit response an SD card returns on the CMD line after the
// command sender releases it. The receiver is armed by a one-cycle START and
// hunts for the start bit on rising edges of the SD clock. Once the start bit
// arrives it shifts in the rest of the frame while running CRC7 over the first
// 40 bits. The receiver then reports one of two outcomes:
//   - the captured word together with CRC/framing status, or
//   - a timeout, if the card stays silent for TIMEOUT_EDGES SD clock edges.
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst        synchronous reset, active-high
//   sd_clk_in  SD clock level produced by the command sender
//   cmd_in     CMD pad level (pulled up, idles at 1)
//   start      one-cycle pulse that arms the receiver
//   check_crc  1 = verify CRC7, 0 = ignore it (R3 carries all ones)
//   busy       high from an accepted start until the result pulse
//   resp_data  captured response, bit 47 is the first bit on the wire
//   resp_valid one-cycle pulse, a full frame was captured
//   crc_err    CRC7 mismatch, valid with resp_valid and held afterwards
//   frame_err  transmission bit not 0 or end bit not 1, held like crc_err
//   timeout    one-cycle pulse, the card stayed silent for the whole window

module sd_cmd_resp_rx #(
    parameter int TIMEOUT_EDGES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_clk_in,
    input  logic        cmd_in,
    input  logic        start,
    input  logic        check_crc,
    output logic        busy,
    output logic [47:0] resp_data,
    output logic        resp_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        timeout
);

    localparam int EDGE_W = $clog2(TIMEOUT_EDGES + 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX  = '1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(TIMEOUT_EDGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_next;
    logic              sd_clk_q;
    logic              sample_edge;
    logic [EDGE_W-1:0] edge_cnt, edge_cnt_next;
    logic [5:0]        bit_cnt, bit_cnt_next;
    logic [46:0]       shift_reg, shift_reg_next;
    logic [6:0]        crc, crc_next;
    logic              check_crc_q, check_crc_next;
    logic [47:0]       resp_data_next;
    logic              resp_valid_next;
    logic              crc_err_next;
    logic              frame_err_next;
    logic              timeout_next;
    logic [47:0]       word;
    logic              crc_fb;
    logic [6:0]        crc_step;

    // A sample edge is a rising edge of the SD clock as seen through one
    // register stage; cmd_in is only looked at on those cycles.
    assign sample_edge = sd_clk_in & ~sd_clk_q;

    // The word as it would look with the current cmd_in shifted in, and the
    // CRC7 (x^7 + x^3 + 1) state after absorbing that same bit.
    assign word     = {shift_reg, cmd_in};
    assign crc_fb   = crc[6] ^ cmd_in;
    assign crc_step = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);

    assign busy = (state != IDLE);

    // Next-state and datapath logic. Results are registered on the cycle
    // that samples the 48th bit so they are visible during DONE, which makes
    // resp_valid appear exactly one cycle after the last sample. A start that
    // lands on the timeout pulse cycle is dropped so the pulse is never
    // followed by a silent re-arm.
    always_comb begin
        state_next      = state;
        edge_cnt_next   = edge_cnt;
        bit_cnt_next    = bit_cnt;
        shift_reg_next  = shift_reg;
        crc_next        = crc;
        check_crc_next  = check_crc_q;
        resp_data_next  = resp_data;
        resp_valid_next = 1'b0;
        crc_err_next    = crc_err;
        frame_err_next  = frame_err;
        timeout_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !timeout) begin
                    state_next     = WAIT_START;
                    edge_cnt_next  = '0;
                    bit_cnt_next   = '0;
                    shift_reg_next = '0;
                    crc_next       = '0;
                    check_crc_next = check_crc;
                end
            end

            WAIT_START: begin
                if (sample_edge) begin
                    if (!cmd_in) begin
                        shift_reg_next = word[46:0];
                        crc_next       = crc_step;
                        bit_cnt_next   = 6'd1;
                        state_next     = SHIFT;
                    end else begin
                        if (edge_cnt != EDGE_MAX) begin
                            edge_cnt_next = edge_cnt + 1'b1;
                        end
                        if (edge_cnt >= EDGE_LAST) begin
                            timeout_next = 1'b1;
                            state_next   = IDLE;
                        end
                    end
                end
            end

            SHIFT: begin
                if (sample_edge) begin
                    shift_reg_next = word[46:0];
                    // CRC covers bits 47..8, i.e. the first 40 bits received
                    if (bit_cnt < 6'd40) begin
                        crc_next = crc_step;
                    end
                    if (bit_cnt != 6'd63) begin
                        bit_cnt_next = bit_cnt + 6'd1;
                    end
                    if (bit_cnt == 6'd47) begin
                        state_next      = DONE;
                        resp_data_next  = word;
                        resp_valid_next = 1'b1;
                        frame_err_next  = word[46] | ~word[0];
                        crc_err_next    = check_crc_q & (crc != word[7:1]);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including any
    // frame in flight, without producing a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sd_clk_q    <= 1'b0;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            crc         <= '0;
            check_crc_q <= 1'b0;
            resp_data   <= '0;
            resp_valid  <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            sd_clk_q    <= sd_clk_in;
            edge_cnt    <= edge_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_reg_next;
            crc         <= crc_next;
            check_crc_q <= check_crc_next;
            resp_data   <= resp_data_next;
            resp_valid  <= resp_valid_next;
            crc_err     <= crc_err_next;
            frame_err   <= frame_err_next;
            timeout     <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb_sd_cmd_resp_rx
//
// Drives SD-clocked response frames and silent periods into sd_cmd_resp_rx.
// Each transaction pushes its expected outcome (word, flags, and the cycle the
// pulse must appear in) into a queue; an independent monitor pops an entry
// whenever the receiver pulses resp_valid or timeout and compares. Expected
// CRC7 values come from polynomial long division rather than a bit-serial LFSR.

module tb_sd_cmd_resp_rx;

    localparam int TIMEOUT_EDGES = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sd_clk_in = 1'b0;
    logic        cmd_in = 1'b1;
    logic        start = 1'b0;
    logic        check_crc = 1'b0;
    logic        busy;
    logic [47:0] resp_data;
    logic        resp_valid;
    logic        crc_err;
    logic        frame_err;
    logic        timeout;

    typedef struct {
        bit          isTimeout;
        logic [47:0] data;
        bit          crcErr;
        bit          frameErr;
        int unsigned cyc;
    } exp_t;

    exp_t        expQ[$];
    exp_t        popped;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          inReset = 1'b1;
    logic [47:0] heldData = '0;
    bit          heldCrc = 1'b0;
    bit          heldFrame = 1'b0;

    sd_cmd_resp_rx #(.TIMEOUT_EDGES(TIMEOUT_EDGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .sd_clk_in  (sd_clk_in),
        .cmd_in     (cmd_in),
        .start      (start),
        .check_crc  (check_crc),
        .busy       (busy),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .crc_err    (crc_err),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    // System clock and a free-running cycle counter used to time pulses
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1
    function automatic logic [6:0] modelCrc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        end
        return r[6:0];
    endfunction

    function automatic exp_t modelFrame(input logic [47:0] data, input bit chk, input int unsigned pulseCyc);
        exp_t e;
        e.isTimeout = 1'b0;
        e.data      = data;
        e.crcErr    = chk && (modelCrc7(data[47:8]) != data[7:1]);
        e.frameErr  = data[46] || !data[0];
        e.cyc       = pulseCyc;
        return e;
    endfunction

    // Monitor: consume one expectation per result pulse and keep checking
    // that resp_data and the error flags hold between pulses
    always @(negedge clk) begin
        if (!inReset) begin
            if (resp_valid || timeout) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", 64'({resp_valid, timeout}), 64'(0));
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("pulse_cycle", 64'(cyc), 64'(popped.cyc));
                    checkOutput("timeout_pulse", 64'(timeout), 64'(popped.isTimeout));
                    checkOutput("resp_valid_pulse", 64'(resp_valid), 64'(!popped.isTimeout));
                    if (!popped.isTimeout) begin
                        heldData  = popped.data;
                        heldCrc   = popped.crcErr;
                        heldFrame = popped.frameErr;
                        checkOutput("busy_at_valid", 64'(busy), 64'(1));
                    end else begin
                        checkOutput("busy_at_timeout", 64'(busy), 64'(0));
                    end
                end
            end
            checkOutput("resp_data", 64'(resp_data), 64'(heldData));
            checkOutput("crc_err", 64'(crc_err), 64'(heldCrc));
            checkOutput("frame_err", 64'(frame_err), 64'(heldFrame));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SD clock period up to its rising edge; returns just after the
    // CLK edge that samples cmd_in, with sd_clk_in still high
    task automatic sdEdge(input bit b);
        sd_clk_in = 1'b0;
        cmd_in    = b;
        tick();
        tick();
        sd_clk_in = 1'b1;
        tick();
    endtask

    task automatic pulseStart(input bit chk);
        check_crc = chk;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check_crc = !chk;
        checkOutput("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 20 && expQ.size() > 0; i++) tick();
        if (expQ.size() > 0) begin
            checkOutput("missing_pulse", 64'(expQ.size()), 64'(0));
            expQ.delete();
        end
        tick();
    endtask

    task automatic resetDut();
        inReset = 1'b1;
        rst     = 1'b1;
        start   = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_timeout", 64'(timeout), 64'(0));
        checkOutput("rst_crc_err", 64'(crc_err), 64'(0));
        checkOutput("rst_frame_err", 64'(frame_err), 64'(0));
        checkOutput("rst_resp_data", 64'(resp_data), 64'(0));
        rst       = 1'b0;
        heldData  = '0;
        heldCrc   = 1'b0;
        heldFrame = 1'b0;
        inReset   = 1'b0;
    endtask

    // Full response transaction: arm, idle edges, 48 frame bits. Optionally
    // fires a stray start mid-frame and another on the DONE cycle.
    task automatic applyStimulus(input logic [47:0] data, input bit chk, input int idleEdges,
                                 input bit strayStart);
        pulseStart(chk);
        for (int i = 0; i < idleEdges; i++) begin
            sdEdge(1'b1);
            tick();
        end
        for (int i = 47; i >= 0; i--) begin
            sdEdge(data[i]);
            if (i == 0) expQ.push_back(modelFrame(data, chk, cyc));
            if (strayStart && (i == 30 || i == 0)) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                if (i == 0) checkOutput("start_at_done_ignored", 64'(busy), 64'(0));
            end else begin
                tick();
            end
        end
        cmd_in = 1'b1;
        waitDrain();
    endtask

    // No response: cmd_in stays high for the whole timeout window
    task automatic applyTimeout(input bit strayStart);
        exp_t e;
        pulseStart(1'b1);
        for (int i = 0; i < TIMEOUT_EDGES; i++) begin
            sdEdge(1'b1);
            if (i == TIMEOUT_EDGES - 1) begin
                e.isTimeout = 1'b1;
                e.data      = '0;
                e.crcErr    = 1'b0;
                e.frameErr  = 1'b0;
                e.cyc       = cyc;
                expQ.push_back(e);
            end
            if (strayStart && i == TIMEOUT_EDGES - 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                checkOutput("start_at_timeout_ignored", 64'(busy), 64'(0));
            end else begin
                tick();
            end
        end
        waitDrain();
        checkOutput("busy_after_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [39:0] hdr;
        logic [37:0] rb;
        logic [6:0]  crcField;
        bit          chk;

        resetDut();

        applyTimeout(1'b1);
        applyStimulus(48'h08_000001AA_13, 1'b1, 5, 1'b0);
        applyStimulus(48'h08_000001AA_1B, 1'b1, 5, 1'b0);
        applyStimulus(48'h3F_00FF8000_FF, 1'b0, 3, 1'b0);
        applyStimulus(48'h3F_00FF8000_FF, 1'b1, 3, 1'b0);
        applyStimulus(48'h40_00000000_95, 1'b1, 2, 1'b0);
        applyStimulus(48'h08_000001AA_13, 1'b1, TIMEOUT_EDGES - 1, 1'b1);

        // Reset in the middle of a frame: no pulse, then a clean capture
        pulseStart(1'b1);
        for (int i = 0; i < 3; i++) begin
            sdEdge(1'b1);
            tick();
        end
        begin
            logic [47:0] r7;
            r7 = 48'h08_000001AA_13;
            for (int i = 47; i > 27; i--) begin
                sdEdge(r7[i]);
                tick();
            end
        end
        resetDut();
        applyStimulus(48'h08_000001AA_13, 1'b1, 4, 1'b0);

        // Randomised frames and occasional silent periods
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                applyTimeout(1'($urandom_range(0, 1)));
            end else begin
                rb[31:0]  = $urandom();
                rb[37:32] = 6'($urandom());
                hdr       = {1'b0, ($urandom_range(0, 3) == 0), rb};
                crcField  = ($urandom_range(0, 2) == 0) ? 7'($urandom()) : modelCrc7(hdr);
                chk       = 1'($urandom_range(0, 1));
                applyStimulus({hdr, crcField, ($urandom_range(0, 4) != 0)}, chk,
                              int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
